// File: rtl/bht_pkg.sv
// bht_pkg: shared definitions for the branch history table / target buffer.
//   cnt_t       2-bit saturating counter encoding (SNT/WNT/WT/ST)
//   CNT_INIT_T  counter value for an entry allocated by a taken branch
//   CNT_INIT_NT counter value for an entry allocated by a not-taken branch
//   sat_cnt     next counter value after one resolved outcome
package bht_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_t;

    localparam cnt_t CNT_INIT_T  = WT;
    localparam cnt_t CNT_INIT_NT = WNT;

    // Counter saturates at both ends so a long run of one outcome
    // never wraps around to the opposite prediction.
    function automatic cnt_t sat_cnt(input cnt_t cnt, input logic taken);
        cnt_t res;
        res = cnt;
        if (taken) begin
            if (cnt != ST) res = cnt_t'(cnt + 2'd1);
        end else begin
            if (cnt != SNT) res = cnt_t'(cnt - 2'd1);
        end
        return res;
    endfunction

endpackage

// File: rtl/bht_btb_if.sv
// bht_btb_if: fetch query, resolved-branch write-back and flush bus.
//   master : drives flush, upd_*, qry_pc; receives pred_*, occupancy
//   slave  : the predictor itself
interface bht_btb_if #(
    parameter int AW      = 12,
    parameter int ENTRIES = 8
);
    localparam int OW = $clog2(ENTRIES + 1);

    logic          flush;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic [AW-1:0] upd_target;
    logic          upd_taken;
    logic [AW-1:0] qry_pc;
    logic          pred_hit;
    logic          pred_taken;
    logic [AW-1:0] pred_target;
    logic [OW-1:0] occupancy;

    modport master (
        output flush, upd_valid, upd_pc, upd_target, upd_taken, qry_pc,
        input  pred_hit, pred_taken, pred_target, occupancy
    );

    modport slave (
        input  flush, upd_valid, upd_pc, upd_target, upd_taken, qry_pc,
        output pred_hit, pred_taken, pred_target, occupancy
    );
endinterface

// File: rtl/bht_entry.sv
// bht_entry: one fully-associative predictor entry.
//   clk, rst_n          clock / async active-low reset
//   flush               invalidate this entry at the next edge
//   alloc               overwrite this entry with the write-back branch
//   upd_hit             train this entry with the write-back outcome
//   upd_pc/target/taken write-back branch fields
//   qry_pc              fetch PC
//   qry_match/upd_match valid entry whose tag equals qry_pc / upd_pc
//   valid, target, cnt  entry state for the top-level muxes and occupancy
module bht_entry
    import bht_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          alloc,
    input  logic          upd_hit,
    input  logic [AW-1:0] upd_pc,
    input  logic [AW-1:0] upd_target,
    input  logic          upd_taken,
    input  logic [AW-1:0] qry_pc,
    output logic          qry_match,
    output logic          upd_match,
    output logic          valid,
    output logic [AW-1:0] target,
    output cnt_t          cnt
);

    logic [AW-1:0] tag;

    // Flush beats any same-cycle write; a trained entry keeps its old
    // target on a not-taken outcome so the fall-through is never stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            tag    <= '0;
            target <= '0;
            cnt    <= WNT;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (alloc) begin
            valid  <= 1'b1;
            tag    <= upd_pc;
            target <= upd_target;
            cnt    <= upd_taken ? CNT_INIT_T : CNT_INIT_NT;
        end else if (upd_hit) begin
            cnt <= sat_cnt(cnt, upd_taken);
            if (upd_taken) target <= upd_target;
        end
    end

    assign qry_match = valid && (tag == qry_pc);
    assign upd_match = valid && (tag == upd_pc);

endmodule

// File: rtl/bht_btb.sv
// bht_btb: fully-associative branch history table / branch target buffer.
//   clk, rst_n  clock / async active-low reset
//   bus         bht_btb_if slave: flush, upd_valid/pc/target/taken, qry_pc in;
//               pred_hit/taken/target, occupancy out
// Queries are combinational on the pre-edge table; write-backs train a hit
// entry or allocate round-robin on a miss.
module bht_btb
    import bht_pkg::*;
#(
    parameter int AW       = 12,
    parameter int ENTRIES  = 8,
    parameter int ALLOC_NT = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    bht_btb_if.slave bus
);

    localparam int PW = $clog2(ENTRIES);
    localparam int OW = $clog2(ENTRIES + 1);

    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] qry_match;
    logic [ENTRIES-1:0] upd_match;
    logic [ENTRIES-1:0] qry_sel;
    logic [ENTRIES-1:0] upd_sel;
    logic [ENTRIES-1:0] alloc;
    logic [ENTRIES-1:0] upd_hit;
    logic [ENTRIES-1:0] pred_bit;
    logic [AW-1:0]      target [ENTRIES];
    cnt_t               cnt    [ENTRIES];
    logic [PW-1:0]      ptr;
    logic [OW-1:0]      occ;
    logic [AW-1:0]      target_mux;
    logic               alloc_en;

    // x & -x isolates the lowest set bit: lowest matching index wins.
    assign qry_sel = qry_match & (~qry_match + ENTRIES'(1));
    assign upd_sel = upd_match & (~upd_match + ENTRIES'(1));

    assign alloc_en = bus.upd_valid && (upd_match == '0) &&
                      (bus.upd_taken || (ALLOC_NT != 0));

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        assign alloc[i]    = alloc_en && (ptr == PW'(i));
        assign upd_hit[i]  = bus.upd_valid && upd_sel[i];
        assign pred_bit[i] = cnt[i][1];

        bht_entry #(.AW(AW)) u_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (bus.flush),
            .alloc      (alloc[i]),
            .upd_hit    (upd_hit[i]),
            .upd_pc     (bus.upd_pc),
            .upd_target (bus.upd_target),
            .upd_taken  (bus.upd_taken),
            .qry_pc     (bus.qry_pc),
            .qry_match  (qry_match[i]),
            .upd_match  (upd_match[i]),
            .valid      (valid[i]),
            .target     (target[i]),
            .cnt        (cnt[i])
        );
    end

    // One-hot AND-OR mux; an all-zero select yields a zero target.
    always_comb begin
        target_mux = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            target_mux = target_mux | ({AW{qry_sel[i]}} & target[i]);
        end
    end

    // Replacement pointer wraps naturally since ENTRIES is a power of two.
    // Occupancy only grows when the victim slot was empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            occ <= '0;
        end else if (bus.flush) begin
            ptr <= '0;
            occ <= '0;
        end else if (alloc_en) begin
            ptr <= ptr + PW'(1);
            if (!valid[ptr]) occ <= occ + OW'(1);
        end
    end

    assign bus.pred_hit    = |qry_match;
    assign bus.pred_taken  = |(qry_sel & pred_bit);
    assign bus.pred_target = target_mux;
    assign bus.occupancy   = occ;

endmodule
